// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: opcode decoder and configuration registers for the flight
// controller, with link watchdog, NACK, thrust clip and calibration abort.
module cmd_cfg_mc #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 16,
  parameter int THRST_W = 9,
  parameter int TMR_W   = 26,
  parameter int WDOG_W  = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_rdy,
  input  logic [7:0]               cmd,
  input  logic [DATA_W-1:0]        data,
  input  logic [7:0]               batt,
  input  logic                     cnv_cmplt,
  input  logic                     cal_done,
  output logic [NUM_CH*DATA_W-1:0] setpt,
  output logic [THRST_W-1:0]       thrst,
  output logic                     motors_off,
  output logic [7:0]               resp,
  output logic                     send_resp,
  output logic                     clr_cmd_rdy,
  output logic                     strt_cnv,
  output logic                     strt_cal,
  output logic                     inertial_cal,
  output logic                     wdog_trip
);
  localparam logic [7:0] ACK_B  = 8'hA5;
  localparam logic [7:0] NACK_B = 8'hEE;
  localparam logic [5:0] NCH    = 6'(NUM_CH);
  localparam logic [DATA_W-1:0] THR_MAX =
    {DATA_W{1'b1}} >> (DATA_W - THRST_W);

  typedef enum logic [2:0] {
    IDLE, BATT, ACK, RAMP, CAL
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0]  tmr;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_full;
  logic              wdog_flag;
  logic              cal_valid;

  logic       is_batt, is_thr, is_cal;
  logic       is_emer, is_off, is_stat;
  logic       is_ch, ch_ok;
  logic [4:0] ch;

  logic       accept, abort, ld_resp;
  logic       do_emer, do_off;
  logic [7:0] resp_nxt;

  always_comb begin
    is_batt = cmd == 8'h01;
    is_thr  = cmd == 8'h05;
    is_cal  = cmd == 8'h06;
    is_emer = cmd == 8'h07;
    is_off  = cmd == 8'h08;
    is_stat = cmd == 8'h09;
    is_ch   = (cmd >= 8'h02 && cmd <= 8'h04)
            || cmd[7:5] == 3'b001;
    ch      = cmd[5] ? cmd[4:0] : cmd[4:0] - 5'd2;
    ch_ok   = is_ch && ({1'b0, ch} < NCH);
  end

  assign wdog_full = &wdog;

  always_comb begin
    state_nxt    = state;
    send_resp    = 1'b0;
    clr_cmd_rdy  = 1'b0;
    strt_cnv     = 1'b0;
    strt_cal     = 1'b0;
    inertial_cal = 1'b0;
    wdog_trip    = 1'b0;
    accept       = 1'b0;
    abort        = 1'b0;
    ld_resp      = 1'b0;
    resp_nxt     = ACK_B;
    unique case (state)
      IDLE: begin
        if (cmd_rdy) begin
          accept = 1'b1;
          unique case (1'b1)
            is_batt: begin
              strt_cnv  = 1'b1;
              state_nxt = BATT;
            end
            is_cal: begin
              clr_cmd_rdy = 1'b1;
              state_nxt   = RAMP;
            end
            default: begin
              ld_resp   = 1'b1;
              state_nxt = ACK;
              if (is_stat)
                resp_nxt = {wdog_flag, motors_off,
                            cal_valid, 5'b0};
              else if (!(ch_ok || is_thr || is_emer || is_off))
                resp_nxt = NACK_B;
            end
          endcase
        end else if (!motors_off && wdog_full) begin
          wdog_trip = 1'b1;
        end
      end
      BATT: begin
        if (cnv_cmplt) begin
          ld_resp   = 1'b1;
          resp_nxt  = batt;
          state_nxt = ACK;
        end
      end
      ACK: begin
        send_resp   = 1'b1;
        clr_cmd_rdy = 1'b1;
        state_nxt   = IDLE;
      end
      RAMP: begin
        abort = cmd_rdy && (is_emer || is_off);
        if (abort) begin
          ld_resp   = 1'b1;
          state_nxt = ACK;
        end else if (&tmr) begin
          strt_cal  = 1'b1;
          state_nxt = CAL;
        end
      end
      CAL: begin
        inertial_cal = 1'b1;
        abort = cmd_rdy && (is_emer || is_off);
        if (abort || cal_done) begin
          ld_resp   = 1'b1;
          state_nxt = ACK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign do_emer = wdog_trip || ((accept || abort) && is_emer);
  assign do_off  = (accept || abort) && is_off;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Watchdog only runs while idle with motors live; anything else parks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr  <= '0;
      wdog <= '0;
    end else begin
      tmr  <= (state == RAMP) ? tmr + 1'b1 : '0;
      wdog <= (state == IDLE && !motors_off && !cmd_rdy
               && !wdog_full) ? wdog + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      setpt      <= '0;
      thrst      <= '0;
      motors_off <= 1'b1;
      resp       <= ACK_B;
      wdog_flag  <= 1'b0;
      cal_valid  <= 1'b0;
    end else begin
      if (ld_resp) resp <= resp_nxt;
      if (do_emer) begin
        setpt <= '0;
        thrst <= '0;
      end else begin
        if (accept && ch_ok) begin
          for (int k = 0; k < NUM_CH; k++)
            if (ch == 5'(k))
              setpt[k*DATA_W +: DATA_W] <= data;
        end
        if (accept && is_thr)
          thrst <= (data > THR_MAX) ? '1 : data[THRST_W-1:0];
      end
      if (do_off)
        motors_off <= 1'b1;
      else if (accept && is_cal)
        motors_off <= 1'b0;
      if (accept && is_cal)
        cal_valid <= 1'b0;
      else if (state == CAL && cal_done)
        cal_valid <= 1'b1;
      if (accept)
        wdog_flag <= 1'b0;
      else if (wdog_trip)
        wdog_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// tb_cmd_cfg_mc: directed bench with a transaction-level model of the
// command unit, compared against the DUT on every cycle.
module tb_cmd_cfg_mc;
  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 16;
  localparam int THRST_W = 9;
  localparam int TMR_W   = 4;
  localparam int WDOG_W  = 5;
  localparam int THR_MAX = (1 << THRST_W) - 1;
  localparam logic [7:0] ACK_B  = 8'hA5;
  localparam logic [7:0] NACK_B = 8'hEE;

  logic clk = 1'b0;
  logic rst;
  logic cmd_rdy;
  logic [7:0] cmd;
  logic [DATA_W-1:0] data;
  logic [7:0] batt;
  logic cnv_cmplt;
  logic cal_done;
  logic [NUM_CH*DATA_W-1:0] setpt;
  logic [THRST_W-1:0] thrst;
  logic motors_off;
  logic [7:0] resp;
  logic send_resp, clr_cmd_rdy, strt_cnv;
  logic strt_cal, inertial_cal, wdog_trip;

  always #5 clk = ~clk;

  cmd_cfg_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .THRST_W(THRST_W),
    .TMR_W(TMR_W), .WDOG_W(WDOG_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd),
    .data(data), .batt(batt), .cnv_cmplt(cnv_cmplt),
    .cal_done(cal_done), .setpt(setpt), .thrst(thrst),
    .motors_off(motors_off), .resp(resp),
    .send_resp(send_resp), .clr_cmd_rdy(clr_cmd_rdy),
    .strt_cnv(strt_cnv), .strt_cal(strt_cal),
    .inertial_cal(inertial_cal), .wdog_trip(wdog_trip)
  );

  logic [DATA_W-1:0] m_set [NUM_CH];
  logic [THRST_W-1:0] m_thrst;
  logic m_moff, m_calv, m_wflag;
  logic [7:0] m_resp;
  logic e_send, e_clr, e_cnv, e_cal, e_ical, e_trip;
  int errs = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] m_pack();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++)
      v[k*DATA_W +: DATA_W] = m_set[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("setpt", setpt, m_pack());
      chk("thrst", thrst, m_thrst);
      chk("motors_off", motors_off, m_moff);
      chk("resp", resp, m_resp);
      chk("send_resp", send_resp, e_send);
      chk("clr_cmd_rdy", clr_cmd_rdy, e_clr);
      chk("strt_cnv", strt_cnv, e_cnv);
      chk("strt_cal", strt_cal, e_cal);
      chk("inertial_cal", inertial_cal, e_ical);
      chk("wdog_trip", wdog_trip, e_trip);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    e_send = 0; e_clr = 0; e_cnv = 0;
    e_cal = 0; e_ical = 0; e_trip = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_set[k] = '0;
    m_thrst = '0;
    m_moff  = 1'b1;
    m_resp  = ACK_B;
    m_calv  = 1'b0;
    m_wflag = 1'b0;
  endtask

  task automatic emer();
    for (int k = 0; k < NUM_CH; k++) m_set[k] = '0;
    m_thrst = '0;
  endtask

  // Effect of one immediate command; returns the response byte.
  task automatic model_cmd(input logic [7:0] op,
                           input logic [DATA_W-1:0] d,
                           output logic [7:0] r);
    logic [7:0] st;
    int k;
    st = {m_wflag, m_moff, m_calv, 5'b0};
    m_wflag = 1'b0;
    k = -1;
    if (op >= 8'h20 && op <= 8'h3F) k = int'(op) - 32;
    else if (op >= 8'h02 && op <= 8'h04) k = int'(op) - 2;
    r = NACK_B;
    if (k >= 0) begin
      if (k < NUM_CH) begin
        m_set[k] = d;
        r = ACK_B;
      end
    end else begin
      case (op)
        8'h05: begin
          m_thrst = (int'(d) > THR_MAX) ? THRST_W'(THR_MAX)
                                       : THRST_W'(d);
          r = ACK_B;
        end
        8'h07: begin emer(); r = ACK_B; end
        8'h08: begin m_moff = 1'b1; r = ACK_B; end
        8'h09: r = st;
        default: r = NACK_B;
      endcase
    end
  endtask

  task automatic issue(input logic [7:0] op,
                       input logic [DATA_W-1:0] d);
    logic [7:0] r;
    cmd = op; data = d; cmd_rdy = 1'b1;
    tick();
    model_cmd(op, d, r);
    m_resp = r; e_send = 1; e_clr = 1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  task automatic req_batt(input logic [7:0] b, input int dly);
    cmd = 8'h01; data = '0; cmd_rdy = 1'b1;
    e_cnv = 1; m_wflag = 1'b0;
    for (int i = 1; i < dly; i++) tick();
    tick();
    cnv_cmplt = 1'b1; batt = b;
    tick();
    cnv_cmplt = 1'b0; batt = ~b;
    m_resp = b; e_send = 1; e_clr = 1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  // mode 0: normal, 1: MTRS_OFF abort in CAL, 2: EMER_LAND abort in RAMP
  task automatic cal_run(input int mode);
    cmd = 8'h06; data = '0; cmd_rdy = 1'b1;
    e_clr = 1; m_wflag = 1'b0;
    tick();
    cmd_rdy = 1'b0; m_moff = 1'b0; m_calv = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (mode == 2 && i == 5) begin
        cmd = 8'h07; cmd_rdy = 1'b1;
        tick();
        emer(); m_resp = ACK_B; e_send = 1; e_clr = 1;
        tick();
        cmd_rdy = 1'b0;
        return;
      end
      if (i == 15) e_cal = 1;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      e_ical = 1;
    end
    if (mode == 1) begin
      cmd = 8'h08; cmd_rdy = 1'b1;
      tick();
      m_moff = 1'b1;
    end else begin
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0; m_calv = 1'b1;
    end
    m_resp = ACK_B; e_send = 1; e_clr = 1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_rdy = 1'b0; cmd = '0; data = '0;
    batt = '0; cnv_cmplt = 1'b0; cal_done = 1'b0;
    model_reset();
    e_send = 0; e_clr = 0; e_cnv = 0;
    e_cal = 0; e_ical = 0; e_trip = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_resp", resp, 8'hA5);
    chk("rst_moff", motors_off, 1'b1);
    chk("rst_setpt", setpt, 48'h0);
    chk("rst_thrst", thrst, 9'h0);
    rst = 1'b0;
    tick();

    issue(8'h21, 16'h8001);
    chk("set_ch1", setpt[31:16], 16'h8001);
    issue(8'h02, 16'h7FFF);
    issue(8'h04, 16'h0042);
    chk("alias_ch2", setpt[47:32], 16'h0042);
    issue(8'h23, 16'h1111);
    chk("nack_ch3", resp, 8'hEE);
    issue(8'h55, 16'h2222);
    chk("nack_55", resp, 8'hEE);

    issue(8'h05, 16'h0300);
    chk("thr_clip", thrst, 9'h1FF);
    issue(8'h05, 16'h0123);
    chk("thr_pass", thrst, 9'h123);
    issue(8'h05, 16'h01FF);
    issue(8'h05, 16'h0200);
    chk("thr_edge", thrst, 9'h1FF);

    issue(8'h09, '0);
    chk("stat_rst", resp, 8'h40);

    cnv_cmplt = 1'b1; batt = 8'h11;
    tick();
    cnv_cmplt = 1'b0;
    tick();
    req_batt(8'h9C, 5);
    chk("batt", resp, 8'h9C);

    issue(8'h07, '0);
    chk("emer", setpt, 48'h0);
    issue(8'h20, 16'h1111);

    cal_run(0);
    cal_run(1);
    chk("abort_moff", motors_off, 1'b1);
    repeat (20) tick();
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    tick();
    issue(8'h09, '0);
    chk("stat_abort", resp, 8'h40);

    cal_run(0);
    issue(8'h20, 16'h1234);
    issue(8'h05, 16'h0080);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 31) e_trip = 1;
    end
    tick();
    emer(); m_wflag = 1'b1;
    chk("wd_thrst", thrst, 9'h0);
    issue(8'h09, '0);
    chk("stat_wdog", resp, 8'hA0);
    issue(8'h09, '0);
    chk("stat_clr", resp, 8'h20);
    for (int i = 1; i <= 31; i++) tick();
    issue(8'h22, 16'h5555);
    cal_run(2);
    issue(8'h08, '0);

    cmd = 8'h01; data = '0; cmd_rdy = 1'b1;
    e_cnv = 1; m_wflag = 1'b0;
    tick(); tick();
    rst = 1'b1; cmd_rdy = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("mid_rst_resp", resp, 8'hA5);
    issue(8'h22, 16'h0BEE);
    chk("post_rst", setpt[47:32], 16'h0BEE);
    tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmd_cfg_mc.md
# cmd_cfg_mc

Parametrised command-configuration unit: decodes 8-bit opcodes with DATA_W-bit payloads from the UART/BLE wrapper and drives NUM_CH signed setpoint registers, thrust, motor enable, battery conversion and inertial calibration. It adds four things:
- a link-loss watchdog that forces an emergency land;
- negative acknowledgement of illegal commands;
- thrust clipping;
- abort of a calibration in progress.

It sits between the UART wrapper and the flight controller.

## Interface
- NUM_CH, 3: number of signed setpoint channels (1..16).
- DATA_W, 16: payload and setpoint width.
- THRST_W, 9: thrust width (THRST_W <= DATA_W).
- TMR_W, 26: motor-ramp timer width. Ramp lasts 2^TMR_W-1 cycles.
- WDOG_W, 28: watchdog width. Timeout is 2^WDOG_W-1 cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_rdy  in  1  command valid. Held high until clr_cmd_rdy.
- cmd  in  8  opcode.
- data  in  DATA_W  payload.
- batt  in  8  ADC battery reading.
- cnv_cmplt  in  1  ADC conversion done (1-cycle pulse).
- cal_done  in  1  inertial calibration done (1-cycle pulse).
- setpt  out  NUM_CH*DATA_W  signed setpoints. Channel k is at [k*DATA_W +: DATA_W].
- thrst  out  THRST_W  thrust.
- motors_off  out  1  motors disabled.
- resp  out  8  registered response byte.
- send_resp  out  1  transmit resp (1-cycle pulse).
- clr_cmd_rdy  out  1  consume command (1-cycle pulse).
- strt_cnv  out  1  start ADC conversion (1-cycle pulse).
- strt_cal  out  1  start calibration (1-cycle pulse).
- inertial_cal  out  1  calibration in progress.
- wdog_trip  out  1  watchdog fired (1-cycle pulse).

## Operation
Opcodes (all others NACK):
- 0x01 REQ_BATT.
- 0x02/0x03/0x04: aliases of SET_CH 0/1/2. NACK if the channel index >= NUM_CH.
- 0x05 SET_THRST.
- 0x06 CALIBRATE.
- 0x07 EMER_LAND.
- 0x08 MTRS_OFF.
- 0x09 REQ_STATUS.
- 0x20|k SET_CH k. NACK if k >= NUM_CH.

Responses:
- ACK = 8'hA5; NACK = 8'hEE.
- REQ_BATT returns batt, latched when cnv_cmplt is seen.
- REQ_STATUS returns {wdog_flag, motors_off, cal_valid, 5'b0}.

Register updates:
- SET_CH k: channel k <= data.
- SET_THRST: thrst <= min(data, 2^THRST_W-1), with data treated as unsigned.
- EMER_LAND: all setpoints and thrst <= 0.
- MTRS_OFF: motors_off <= 1.
- CALIBRATE: motors_off <= 0 on entry to RAMP. cal_valid <= 0 on entry to RAMP, and <= 1 on cal_done.

States:
- IDLE: on cmd_rdy, decode the opcode.
  - SET/EMER/MTRS/STATUS/illegal: perform the action, load resp, go to ACK.
  - REQ_BATT: strt_cnv=1, go to BATT.
  - CALIBRATE: clr_cmd_rdy=1, clear the ramp timer, go to RAMP.
- BATT: wait for cnv_cmplt; then resp <= batt and go to ACK. cmd_rdy is ignored.
- ACK: send_resp=1 and clr_cmd_rdy=1 for exactly one cycle, then go to IDLE.
- RAMP: the ramp timer increments. When it is all-ones, strt_cal=1 and go to CAL.
- CAL: inertial_cal=1. On cal_done, resp <= A5 and go to ACK.

Abort during RAMP or CAL:
- A cmd_rdy with EMER_LAND or MTRS_OFF aborts: its action is applied, resp <= A5, go to ACK.
- MTRS_OFF also sets motors_off; EMER_LAND leaves the motors on.
- Neither pulses strt_cal afterwards.
- Any other opcode is left pending (not consumed) until IDLE.

Watchdog:
- Counts only when state==IDLE and motors_off==0. Otherwise it holds at 0.
- It clears on every command accepted in IDLE.
- At all-ones:
  - wdog_trip pulses for one cycle;
  - the EMER_LAND action is applied;
  - wdog_flag <= 1;
  - the counter clears.
- wdog_flag clears on the next accepted command, after that command's REQ_STATUS snapshot.

## Timing
- Reset values:
  - setpt = 0, thrst = 0;
  - motors_off = 1;
  - resp = 8'hA5;
  - all pulses and inertial_cal = 0;
  - wdog_flag = 0, cal_valid = 0;
  - both timers 0; state IDLE.
- Reset mid-operation aborts any state. No response is sent.
- Command at cycle N (IDLE, cmd_rdy high):
  - register write at edge N+1;
  - send_resp and clr_cmd_rdy high in cycle N+1;
  - back in IDLE at N+2.
- REQ_BATT:
  - strt_cnv high in cycle N;
  - cnv_cmplt in cycle M gives send_resp in M+1, carrying the batt value sampled in M.
- CALIBRATE: strt_cal goes high 2^TMR_W-1 cycles after RAMP entry, then inertial_cal holds until the cycle after cal_done.
- Watchdog and command in the same cycle: the command wins. The counter clears and there is no trip.
- cnv_cmplt or cal_done outside its wait state is ignored.

## Test plan
- Reset, then SET_CH 0x21 data 16'h8001 (NUM_CH=3) -> setpt[31:16]=16'h8001, resp=A5, send_resp exactly one cycle at N+1.
- SET_CH 0x23 (NUM_CH=3) and opcode 0x55 -> resp=EE each time, setpt unchanged.
- SET_THRST data 16'h0300 -> thrst=9'h1FF. Then data 16'h0123 -> thrst=9'h123.
- REQ_BATT with batt=8'h9C and cnv_cmplt 5 cycles later -> strt_cnv pulse, then resp=9C and send_resp.
- CALIBRATE (TMR_W=4): motors_off falls, strt_cal at cycle 15, cal_done -> A5. Repeat with MTRS_OFF issued in CAL -> inertial_cal drops, motors_off=1, one A5, no further strt_cal.
- WDOG_W=5, motors on, thrst=9'h080, no commands -> wdog_trip after 31 IDLE cycles, thrst=0, setpts=0. REQ_STATUS then returns 8'h80|cal_valid<<5.
